// File: rtl/exe_stage_mc.sv
// Execute stage: ALU, barrel shifter and branch target in one cycle, plus a multi-cycle shift-add MUL.
// Latency: 1 cycle for ALU ops, DATA_W cycles for MUL. Output register holds while out_ready=0; in_ready drops during MUL.
module exe_stage_mc #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [4:0]        in_ctrl,
    input  logic [3:0]        in_cmd,
    input  logic              in_imm,
    input  logic [23:0]       in_simm24,
    input  logic [11:0]       in_shift_op,
    input  logic [DATA_W-1:0] in_val_rn,
    input  logic [DATA_W-1:0] in_val_rm,
    input  logic [3:0]        in_status,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_ctrl,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_val_rm,
    output logic [3:0]        out_status,
    output logic [ADDR_W-1:0] out_branch_addr
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam int MSB   = DATA_W - 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_acc, r_mcand, r_mplier;
    logic [1:0]          r_mul_cv;

    logic                w_accept, w_is_mul, w_sub, w_cin, w_arith, w_known, w_c, w_v;
    logic [31:0]         w_rot_amt, w_sh_amt;
    logic [DATA_W-1:0]   w_val2, w_b, w_res, w_acc_next;
    logic [DATA_W:0]     w_sum;
    logic [3:0]          w_flags;
    logic [ADDR_W-1:0]   w_baddr;

    function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x, input logic [31:0] n);
        logic [2*DATA_W-1:0] d;
        d = {x, x} >> n;
        return d[DATA_W-1:0];
    endfunction

    assign in_ready = (r_state == S_IDLE) && (!out_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;
    assign w_is_mul = (in_cmd == 4'b1010);
    assign w_baddr  = in_pc + ADDR_W'($signed({in_simm24, 2'b00}));
    assign w_acc_next = r_mplier[0] ? r_acc + r_mcand : r_acc;

    // Operand 2: rotated immediate, raw 12-bit offset for loads/stores, or shifted rm
    always_comb begin
        w_rot_amt = 32'({in_shift_op[11:8], 1'b0}) % 32'(DATA_W);
        w_sh_amt  = 32'(in_shift_op[11:7]) % 32'(DATA_W);
        if (in_imm) begin
            w_val2 = ror(DATA_W'(in_shift_op[7:0]), w_rot_amt);
        end else if (in_ctrl[3] || in_ctrl[2]) begin
            w_val2 = DATA_W'(in_shift_op);
        end else begin
            case (in_shift_op[6:5])
                2'b00:   w_val2 = in_val_rm << w_sh_amt;
                2'b01:   w_val2 = in_val_rm >> w_sh_amt;
                2'b10:   w_val2 = $signed(in_val_rm) >>> w_sh_amt;
                default: w_val2 = ror(in_val_rm, w_sh_amt);
            endcase
        end
    end

    // Subtraction is rn + ~val2 + cin so the adder carry-out is the no-borrow flag
    always_comb begin
        w_sub   = (in_cmd == 4'b0100) || (in_cmd == 4'b0101);
        w_b     = w_sub ? ~w_val2 : w_val2;
        w_cin   = ((in_cmd == 4'b0011) || (in_cmd == 4'b0101)) ? in_status[1] : (in_cmd == 4'b0100);
        w_sum   = {1'b0, in_val_rn} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_cin};
        w_res   = '0;
        w_arith = 1'b0;
        w_known = 1'b1;
        case (in_cmd)
            4'b0001: w_res = w_val2;
            4'b1001: w_res = ~w_val2;
            4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
                w_res   = w_sum[DATA_W-1:0];
                w_arith = 1'b1;
            end
            4'b0110: w_res = in_val_rn & w_val2;
            4'b0111: w_res = in_val_rn | w_val2;
            4'b1000: w_res = in_val_rn ^ w_val2;
            default: w_known = 1'b0;
        endcase
        w_c     = w_arith ? w_sum[DATA_W] : in_status[1];
        w_v     = w_arith ? ((in_val_rn[MSB] == w_b[MSB]) && (w_res[MSB] != in_val_rn[MSB])) : in_status[0];
        w_flags = w_known ? {w_res[MSB], (w_res == '0), w_c, w_v} : in_status;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_acc           <= '0;
            r_mcand         <= '0;
            r_mplier        <= '0;
            r_mul_cv        <= '0;
            out_valid       <= 1'b0;
            out_ctrl        <= '0;
            out_pc          <= '0;
            out_alu_res     <= '0;
            out_val_rm      <= '0;
            out_status      <= '0;
            out_branch_addr <= '0;
        end else if (flush) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            out_valid <= 1'b0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(DATA_W - 1)) begin
                r_state     <= S_IDLE;
                r_cnt       <= '0;
                out_valid   <= 1'b1;
                out_alu_res <= w_acc_next;
                out_status  <= {w_acc_next[MSB], (w_acc_next == '0), r_mul_cv};
            end
        end else if (w_accept) begin
            // Side-band fields load at acceptance; out_valid stays low until MUL finishes
            out_ctrl        <= in_ctrl;
            out_pc          <= in_pc;
            out_val_rm      <= in_val_rm;
            out_branch_addr <= w_baddr;
            if (w_is_mul) begin
                r_state   <= S_MUL;
                r_cnt     <= '0;
                r_acc     <= '0;
                r_mcand   <= in_val_rn;
                r_mplier  <= in_val_rm;
                r_mul_cv  <= in_status[1:0];
                out_valid <= 1'b0;
            end else begin
                out_valid   <= 1'b1;
                out_alu_res <= w_res;
                out_status  <= w_flags;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
